// File: rtl/mux4_rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1-muxed resource among four
//   requesters. One requester is granted at a time. The grant is held until the
//   resource signals completion or until a timeout forces a release. The 2-bit
//   select for the downstream data mux is driven from the same registers as
//   the grant.
//
// Parameters
//   TIMEOUT_CYC  number of ACTIVE cycles without done before a forced release
//                (must be >= 2)
//   CNT_WIDTH    width of the timeout counter; must be able to hold TIMEOUT_CYC
//
// Ports
//   CLK          in   1  clock; all state updates on the rising edge
//   RST          in   1  asynchronous reset, active low
//   req          in   4  request vector; bit i = requester i wants the resource
//   done         in   1  resource finished the current transaction (1-cycle pulse)
//   gnt          out  4  registered one-hot grant; all zero when idle
//   sel          out  2  downstream mux select = index of current/last grant
//   start        out  1  1-cycle pulse in the first cycle of each new grant
//   busy         out  1  high while a grant is active
//   timeout_err  out  1  1-cycle pulse after a grant is force-released by timeout
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       start,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [1:0]           ptr, ptr_nx;
    logic [3:0]           gnt_nx;
    logic [1:0]           sel_nx;
    logic                 start_nx;
    logic                 terr_nx;
    logic                 release_now;
    logic                 timeout_hit;
    logic [2:0]           pick_res;

    // Round-robin search: offsets 1..4 from base. Offset 4 is base itself and
    // is only considered when incl_base is set. The loop runs backwards so the
    // lowest offset that hits wins. Result is {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] r,
                                        input logic [1:0] base,
                                        input logic       incl_base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + k[1:0];
            if (r[idx] && ((k != 4) || incl_base))
                res = {1'b1, idx};
        end
        return res;
    endfunction

    assign timeout_hit = (cnt == CNT_WIDTH'(TIMEOUT_CYC - 1));
    assign release_now = (state == ACTIVE) && (done || timeout_hit);
    assign busy        = (state == ACTIVE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        sel_nx   = sel;
        start_nx = 1'b0;
        terr_nx  = 1'b0;
        pick_res = 3'b000;

        case (state)
            IDLE: begin
                // From idle every requester is eligible; ptr itself is searched last.
                pick_res = pick(req, ptr, 1'b1);
                if (pick_res[2]) begin
                    state_nx = ACTIVE;
                    gnt_nx   = 4'b0001 << pick_res[1:0];
                    sel_nx   = pick_res[1:0];
                    start_nx = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    gnt_nx = 4'b0000;
                end
            end

            ACTIVE: begin
                cnt_nx = cnt + 1'b1;
                if (release_now) begin
                    // done wins over timeout when both happen in the same cycle.
                    terr_nx = ~done;
                    ptr_nx  = sel;
                    // Back-to-back re-grant only goes to a different requester.
                    // A lone re-requester of the served index passes through
                    // IDLE and is picked up there.
                    pick_res = pick(req, sel, 1'b0);
                    if (pick_res[2]) begin
                        gnt_nx   = 4'b0001 << pick_res[1:0];
                        sel_nx   = pick_res[1:0];
                        start_nx = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = 4'b0000;
                        cnt_nx   = '0;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                gnt_nx   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 2'd3;
            gnt         <= 4'b0000;
            sel         <= 2'b00;
            start       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            ptr         <= ptr_nx;
            gnt         <= gnt_nx;
            sel         <= sel_nx;
            start       <= start_nx;
            timeout_err <= terr_nx;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Self-checking bench for mux4_rr_arbiter. Expected output words
//   {gnt, sel, start, busy, timeout_err} are queued when stimulus is driven
//   and compared after the next rising edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       start;
    logic       busy;
    logic       timeout_err;
    logic [8:0] obs;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q [$];

    always #5 CLK = ~CLK;

    mux4_rr_arbiter #(
        .TIMEOUT_CYC(16),
        .CNT_WIDTH  (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .sel        (sel),
        .start      (start),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    assign obs = {gnt, sel, start, busy, timeout_err};

    // flags = {start, busy, timeout_err}
    function automatic logic [8:0] mk(input logic [3:0] g, input logic [1:0] s,
                                      input logic [2:0] flags);
        return {g, s, flags};
    endfunction

    task automatic test_reset();
        logic [8:0] e;
        RST = 1'b0; req = 4'b1111; done = 1'b0;
        exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
        repeat (2) @(posedge CLK);
        #1;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_hold: got=%b exp=%b", obs, e);
        end
        @(negedge CLK);
        RST = 1'b1; req = 4'b0000;
        exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
        @(posedge CLK); #1;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_idle: got=%b exp=%b", obs, e);
        end
        @(negedge CLK);
    endtask

    task automatic test_single();
        logic [3:0] rq [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic       dn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] ex [4];
        logic [8:0] e;
        ex[0] = mk(4'b0001, 2'd0, 3'b110);
        ex[1] = mk(4'b0001, 2'd0, 3'b010);
        ex[2] = mk(4'b0000, 2'd0, 3'b000);
        ex[3] = mk(4'b0000, 2'd0, 3'b000);
        for (int c = 0; c < 4; c++) begin
            req = rq[c]; done = dn[c];
            exp_q.push_back(ex[c]);
            @(posedge CLK); #1;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL single edge%0d: got=%b exp=%b", c, obs, e);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ord [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] g;
        logic [8:0] e;
        // fresh reset so requester 0 has top priority
        RST = 1'b0; req = 4'b0000; done = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 15) begin
                req  = 4'b1111;
                done = ((c % 3) == 0) && (c > 0);
                g    = ord[c / 3];
                exp_q.push_back(mk(4'b0001 << g, g, ((c % 3) == 0) ? 3'b110 : 3'b010));
            end else begin
                req  = 4'b0000;
                done = 1'b1;
                exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
            end
            @(posedge CLK); #1;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL round_robin edge%0d: got=%b exp=%b", c, obs, e);
            end
            @(negedge CLK);
        end
        done = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] rq [9] = '{4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0011,
                              4'b0000, 4'b0011, 4'b0000, 4'b0000};
        logic       dn [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [8:0] ex [9];
        logic [8:0] e;
        ex[0] = mk(4'b0010, 2'd1, 3'b110);
        ex[1] = mk(4'b0010, 2'd1, 3'b010);
        ex[2] = mk(4'b0001, 2'd0, 3'b110);  // back-to-back wrap past 1
        ex[3] = mk(4'b0000, 2'd0, 3'b000);
        ex[4] = mk(4'b0010, 2'd1, 3'b110);
        ex[5] = mk(4'b0000, 2'd1, 3'b000);  // sel holds last index
        ex[6] = mk(4'b0001, 2'd0, 3'b110);  // idle-path wrap with ptr=1
        ex[7] = mk(4'b0000, 2'd0, 3'b000);
        ex[8] = mk(4'b0000, 2'd0, 3'b000);  // done while idle ignored
        for (int c = 0; c < 9; c++) begin
            req = rq[c]; done = dn[c];
            exp_q.push_back(ex[c]);
            @(posedge CLK); #1;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL wrap edge%0d: got=%b exp=%b", c, obs, e);
            end
            @(negedge CLK);
        end
        done = 1'b0;
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        for (int c = 0; c < 37; c++) begin
            done = 1'b0;
            if (c == 0) begin
                req = 4'b0100; exp_q.push_back(mk(4'b0100, 2'd2, 3'b110));
            end else if (c <= 15) begin
                req = 4'b1100; exp_q.push_back(mk(4'b0100, 2'd2, 3'b010));
            end else if (c == 16) begin
                req = 4'b1100; exp_q.push_back(mk(4'b1000, 2'd3, 3'b111));
            end else if (c == 17) begin
                req = 4'b1000; exp_q.push_back(mk(4'b1000, 2'd3, 3'b010));
            end else if (c == 18) begin
                req = 4'b0000; done = 1'b1; exp_q.push_back(mk(4'b0000, 2'd3, 3'b000));
            end else if (c == 19) begin
                req = 4'b0001; exp_q.push_back(mk(4'b0001, 2'd0, 3'b110));
            end else if (c <= 34) begin
                req = 4'b0001; exp_q.push_back(mk(4'b0001, 2'd0, 3'b010));
            end else if (c == 35) begin
                // done coincides with the last allowed cycle: clean release
                req = 4'b0001; done = 1'b1; exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
            end else begin
                req = 4'b0000; exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
            end
            @(posedge CLK); #1;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL timeout edge%0d: got=%b exp=%b", c, obs, e);
            end
            @(negedge CLK);
        end
        done = 1'b0;
    endtask

    task automatic test_drop_req();
        logic [8:0] e;
        for (int c = 0; c < 6; c++) begin
            req  = (c == 0) ? 4'b0010 : 4'b0000;
            done = (c == 5);
            if (c == 0)      exp_q.push_back(mk(4'b0010, 2'd1, 3'b110));
            else if (c < 5)  exp_q.push_back(mk(4'b0010, 2'd1, 3'b010));
            else             exp_q.push_back(mk(4'b0000, 2'd1, 3'b000));
            @(posedge CLK); #1;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL drop_req edge%0d: got=%b exp=%b", c, obs, e);
            end
            @(negedge CLK);
        end
        done = 1'b0;
    endtask

    task automatic test_reset_active();
        logic [8:0] e;
        for (int c = 0; c < 2; c++) begin
            req = 4'b0100; done = 1'b0;
            exp_q.push_back(mk(4'b0100, 2'd2, (c == 0) ? 3'b110 : 3'b010));
            @(posedge CLK); #1;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rst_active grant%0d: got=%b exp=%b", c, obs, e);
            end
        end
        // asynchronous reset, no clock edge in between
        #2;
        RST = 1'b0;
        exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
        #1;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_active async: got=%b exp=%b", obs, e);
        end
        @(negedge CLK);
        req = 4'b1000;
        exp_q.push_back(mk(4'b0000, 2'd0, 3'b000));
        @(posedge CLK); #1;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_active held: got=%b exp=%b", obs, e);
        end
        @(negedge CLK);
        RST = 1'b1; req = 4'b1000;
        exp_q.push_back(mk(4'b1000, 2'd3, 3'b110));
        @(posedge CLK); #1;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_active regrant: got=%b exp=%b", obs, e);
        end
        @(negedge CLK);
        req = 4'b0000; done = 1'b1;
        exp_q.push_back(mk(4'b0000, 2'd3, 3'b000));
        @(posedge CLK); #1;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_active release: got=%b exp=%b", obs, e);
        end
        @(negedge CLK);
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST  = 1'b0;
        req  = 4'b0000;
        done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_drop_req();
        test_reset_active();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
